sdram_ctrl_mc: RTL and testbench
================================

# sdram_ctrl_mc

Parametrised multi-channel SDRAM command controller, next generation of the single-requester controller. It runs the power-up init sequence and arbitrates NCH requesters round-robin, read before write within a channel. It issues ACTIVE/READ/WRITE bursts of per-request length and schedules auto-refresh with bounded postponement. It sits between the memory-client ports and the SDRAM pin driver; it emits command encodings and data-beat strobes, not addresses or data.

## Interface
- NCH, 2: requester channels (1..8)
- LEN_W, 9: burst-length field width
- T_INIT, 20000: power-up wait cycles (200 us at 100 MHz)
- T_RP, 2; T_RFC, 7; T_MRD, 2; T_RCD, 2; CL, 3; T_WR, 2: SDRAM timings in cycles, each ≥1
- T_REFI, 750: cycles per refresh tick
- REF_MAX, 4: max postponed refreshes (≥1)

- clk_100m  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- rd_req  in  NCH  per-channel read request, level, held until xfer_done
- wr_req  in  NCH  per-channel write request, level
- xfer_len  in  NCH*LEN_W  channel i beats at [i*LEN_W +: LEN_W]; 0 means 1
- grant  out  NCH  one-hot owner, ACT through xfer_done; reset 0
- sdram_cmd  out  3  NOP=0, PRE=1, REF=2, MRS=3, ACT=4, RD=5, WR=6; reset NOP
- rd_ack  out  1  read data beat valid; reset 0
- wr_ack  out  1  write data beat taken; reset 0
- xfer_done  out  1  one-cycle pulse, last cycle of a transfer; reset 0
- sys_rw_n  out  1  0 read, 1 write, latched at grant; reset 0
- init_done  out  1  init complete; reset 0
- busy  out  1  high unless init_done and work FSM idle; reset 1
- ref_pending  out  $clog2(REF_MAX+1)  owed refreshes; reset 0

## Operation
- Init FSM: I_WAIT (T_INIT cycles) → I_PRE (1) → I_TRP (T_RP−1) → I_REF1 (1) → I_TRF1 (T_RFC−1) → I_REF2 (1) → I_TRF2 (T_RFC−1) → I_MRS (1) → I_TMRD (T_MRD−1) → I_DONE; sdram_cmd PRE/REF/MRS only in single-cycle states, else NOP. A wait of 0 cycles is skipped.
- Work FSM, active only in I_DONE: W_IDLE, W_ACT, W_TRCD, W_RD, W_CL, W_RDATA, W_WR, W_WDATA, W_TWR, W_AR, W_TRFC.
- Refresh tick: counter runs from init_done, pulses every T_REFI cycles; ref_pending +1 on tick, saturating at REF_MAX; −1 on entering W_AR; tick and entry in the same cycle leave it unchanged.
- W_IDLE priority: (1) ref_pending==REF_MAX → W_AR; (2) any request → grant; (3) ref_pending>0 → W_AR; (4) stay.
- Arbitration: search channels from last_grant+1 modulo NCH; the first with rd_req|wr_req wins; read if rd_req, else write. last_grant resets to NCH−1, so ch0 wins first.
- Read: ACT, T_RCD−1 cycles TRCD, RD cmd, CL−1 cycles W_CL, then W_RDATA with rd_ack for len beats; xfer_done on last beat.
- Write: ACT, TRCD, W_WR (WR cmd, wr_ack=1), W_WDATA for len−1 further wr_ack beats, W_TWR T_WR cycles; xfer_done on last TWR cycle.
- AR: REF cmd one cycle, W_TRFC T_RFC−1 cycles, → W_IDLE.
- Request dropped mid-transfer: ignored; the burst completes.
- xfer_len sampled at grant only.
- rst_n low at any edge: all FSMs, counters, outputs to reset values next cycle, including mid-burst; init restarts from I_WAIT.

## Timing
- Request seen in W_IDLE at edge k → ACT cmd and grant in cycle k+1.
- ACT→RD/WR cmd: exactly T_RCD cycles. RD cmd→first rd_ack: CL cycles.
- Read occupancy ACT→xfer_done: T_RCD+CL+len cycles; W_IDLE the following cycle.
- Write occupancy: T_RCD+len+T_WR cycles.
- Back-to-back requests: one W_IDLE cycle between transfers.
- All outputs registered or decoded from registered state only; no combinational path from req to sdram_cmd.

## Structure
- Shared header sdram_mc_para.v: init/work state encodings, sdram_cmd encodings, default timing parameters.
- Sub-module rr_arbiter (NCH-wide, one-hot grant, rotating pointer updated on accept).
- Counters: single shared cnt_clk for wait states, separate refresh interval counter, beat counter of LEN_W bits.

## Test plan
- T_INIT=10, defaults: cmd PRE at cycle 10, REF at 12, REF at 19, MRS at 26, init_done at cycle 28.
- ch0 rd_req, len=4: ACT, RD 2 cycles later, rd_ack cycles +3..+6 after RD, xfer_done with 4th beat, grant=01 throughout.
- ch0 and ch1 both write-requesting, len=1: grants 01,10,01,10; each write ACT→xfer_done = 5 cycles.
- Continuous reads with T_REFI=20, REF_MAX=2: ref_pending reaches 2, then REF issued before next grant, ref_pending never exceeds 2.
- rst_n low during W_RDATA beat 2: next cycle rd_ack=0, grant=0, cmd NOP, init_done=0, busy=1, ref_pending=0.
- xfer_len=0 read: exactly one rd_ack beat, xfer_done same cycle.

Source files
------------

// File: rtl/sdram_ctrl_mc_pkg.sv
// Shared encodings and default timings for the multi-channel SDRAM
// command controller.
package sdram_ctrl_mc_pkg;

  typedef enum logic [3:0] {
    I_WAIT, I_PRE, I_TRP, I_REF1, I_TRF1,
    I_REF2, I_TRF2, I_MRS, I_TMRD, I_DONE
  } init_e;

  typedef enum logic [3:0] {
    W_IDLE, W_ACT, W_TRCD, W_RD, W_CL, W_RDATA,
    W_WR, W_WDATA, W_TWR, W_AR, W_TRFC
  } work_e;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_PRE = 3'd1,
    CMD_REF = 3'd2,
    CMD_MRS = 3'd3,
    CMD_ACT = 3'd4,
    CMD_RD  = 3'd5,
    CMD_WR  = 3'd6
  } cmd_e;

  localparam int DEF_T_INIT  = 20000;
  localparam int DEF_T_RP    = 2;
  localparam int DEF_T_RFC   = 7;
  localparam int DEF_T_MRD   = 2;
  localparam int DEF_T_RCD   = 2;
  localparam int DEF_CL      = 3;
  localparam int DEF_T_WR    = 2;
  localparam int DEF_T_REFI  = 750;
  localparam int DEF_REF_MAX = 4;

endpackage

// File: rtl/sdram_ctrl_mc_rr_arbiter.sv
// Round-robin arbiter: search starts after the last accepted channel,
// pointer moves only when the owner accepts the grant.
module sdram_ctrl_mc_rr_arbiter #(
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] i_req,
  input  logic           i_accept,
  output logic [NCH-1:0] o_gnt,
  output logic           o_found
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CH_W-1:0] r_last;
  logic [CH_W-1:0] w_idx;

  // Channels above the pointer first, then wrap to the low ones.
  always_comb begin
    o_gnt   = '0;
    o_found = 1'b0;
    w_idx   = r_last;
    for (int j = 0; j < NCH; j++) begin
      if (!o_found && (CH_W'(j) > r_last) && i_req[j]) begin
        o_gnt[j] = 1'b1;
        o_found  = 1'b1;
        w_idx    = CH_W'(j);
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (!o_found && i_req[j]) begin
        o_gnt[j] = 1'b1;
        o_found  = 1'b1;
        w_idx    = CH_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last <= CH_W'(NCH - 1);
    else if (i_accept && o_found)
      r_last <= w_idx;
  end

endmodule

// File: rtl/sdram_ctrl_mc.sv
// Multi-channel SDRAM command controller: power-up init, round-robin
// burst scheduling and postponable auto-refresh.
module sdram_ctrl_mc
  import sdram_ctrl_mc_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int LEN_W   = 9,
  parameter int T_INIT  = DEF_T_INIT,
  parameter int T_RP    = DEF_T_RP,
  parameter int T_RFC   = DEF_T_RFC,
  parameter int T_MRD   = DEF_T_MRD,
  parameter int T_RCD   = DEF_T_RCD,
  parameter int CL      = DEF_CL,
  parameter int T_WR    = DEF_T_WR,
  parameter int T_REFI  = DEF_T_REFI,
  parameter int REF_MAX = DEF_REF_MAX
) (
  input  logic                       clk_100m,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             rd_req,
  input  logic [NCH-1:0]             wr_req,
  input  logic [NCH*LEN_W-1:0]       xfer_len,
  output logic [NCH-1:0]             grant,
  output logic [2:0]                 sdram_cmd,
  output logic                       rd_ack,
  output logic                       wr_ack,
  output logic                       xfer_done,
  output logic                       sys_rw_n,
  output logic                       init_done,
  output logic                       busy,
  output logic [$clog2(REF_MAX+1)-1:0] ref_pending
);

  localparam int CNT_W =
    $clog2(T_INIT + T_RP + T_RFC + T_MRD + T_RCD + CL + T_WR + 2);
  localparam int RC_W = $clog2(T_REFI + 1);
  localparam int PW   = $clog2(REF_MAX + 1);

  init_e            r_init;
  work_e            r_work;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_beat;
  logic [LEN_W-1:0] r_last_beat;
  logic [NCH-1:0]   r_grant;
  logic             r_rw_n;
  logic [RC_W-1:0]  r_rcnt;
  logic [PW-1:0]    r_pend;

  logic [NCH-1:0]   w_gnt;
  logic             w_found;
  logic             w_idle;
  logic             w_force;
  logic             w_accept;
  logic             w_ar_go;
  logic             w_tick;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_last;
  cmd_e             w_cmd;

  sdram_ctrl_mc_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk      (clk_100m),
    .rst_n    (rst_n),
    .i_req    (rd_req | wr_req),
    .i_accept (w_accept),
    .o_gnt    (w_gnt),
    .o_found  (w_found)
  );

  assign w_idle   = (r_init == I_DONE) && (r_work == W_IDLE);
  assign w_force  = w_idle && (r_pend == PW'(REF_MAX));
  assign w_accept = w_idle && !w_force && w_found;
  assign w_ar_go  = w_force || (w_idle && !w_found && (r_pend != '0));
  assign w_tick   = (r_init == I_DONE) && (r_rcnt == RC_W'(T_REFI - 1));

  always_comb begin
    w_len = '0;
    for (int j = 0; j < NCH; j++)
      if (w_gnt[j]) w_len = xfer_len[j*LEN_W +: LEN_W];
  end

  // A length of zero is a single beat, same as one.
  assign w_last = (w_len == '0) ? '0 : w_len - LEN_W'(1);

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_init      <= (T_INIT > 0) ? I_WAIT : I_PRE;
      r_work      <= W_IDLE;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_last_beat <= '0;
      r_grant     <= '0;
      r_rw_n      <= 1'b0;
    end else begin
      case (r_init)
        I_WAIT:
          if (r_cnt == CNT_W'(T_INIT - 1)) begin
            r_init <= I_PRE;
            r_cnt  <= '0;
          end else r_cnt <= r_cnt + CNT_W'(1);
        I_PRE: begin
          r_cnt  <= '0;
          r_init <= (T_RP > 1) ? I_TRP : I_REF1;
        end
        I_TRP:
          if (r_cnt == CNT_W'(T_RP - 2)) begin
            r_init <= I_REF1;
            r_cnt  <= '0;
          end else r_cnt <= r_cnt + CNT_W'(1);
        I_REF1: begin
          r_cnt  <= '0;
          r_init <= (T_RFC > 1) ? I_TRF1 : I_REF2;
        end
        I_TRF1:
          if (r_cnt == CNT_W'(T_RFC - 2)) begin
            r_init <= I_REF2;
            r_cnt  <= '0;
          end else r_cnt <= r_cnt + CNT_W'(1);
        I_REF2: begin
          r_cnt  <= '0;
          r_init <= (T_RFC > 1) ? I_TRF2 : I_MRS;
        end
        I_TRF2:
          if (r_cnt == CNT_W'(T_RFC - 2)) begin
            r_init <= I_MRS;
            r_cnt  <= '0;
          end else r_cnt <= r_cnt + CNT_W'(1);
        I_MRS: begin
          r_cnt  <= '0;
          r_init <= (T_MRD > 1) ? I_TMRD : I_DONE;
        end
        I_TMRD:
          if (r_cnt == CNT_W'(T_MRD - 2)) begin
            r_init <= I_DONE;
            r_cnt  <= '0;
          end else r_cnt <= r_cnt + CNT_W'(1);
        I_DONE:
          case (r_work)
            W_IDLE:
              if (w_ar_go) r_work <= W_AR;
              else if (w_accept) begin
                r_work      <= W_ACT;
                r_grant     <= w_gnt;
                r_rw_n      <= ~|(rd_req & w_gnt);
                r_last_beat <= w_last;
              end
            W_ACT: begin
              r_cnt  <= '0;
              r_work <= (T_RCD > 1) ? W_TRCD : (r_rw_n ? W_WR : W_RD);
            end
            W_TRCD:
              if (r_cnt == CNT_W'(T_RCD - 2)) begin
                r_cnt  <= '0;
                r_work <= r_rw_n ? W_WR : W_RD;
              end else r_cnt <= r_cnt + CNT_W'(1);
            W_RD: begin
              r_cnt  <= '0;
              r_beat <= '0;
              r_work <= (CL > 1) ? W_CL : W_RDATA;
            end
            W_CL:
              if (r_cnt == CNT_W'(CL - 2)) begin
                r_cnt  <= '0;
                r_work <= W_RDATA;
              end else r_cnt <= r_cnt + CNT_W'(1);
            W_RDATA:
              if (r_beat == r_last_beat) begin
                r_work  <= W_IDLE;
                r_grant <= '0;
              end else r_beat <= r_beat + LEN_W'(1);
            W_WR: begin
              r_cnt <= '0;
              if (r_last_beat == '0) r_work <= W_TWR;
              else begin
                r_work <= W_WDATA;
                r_beat <= LEN_W'(1);
              end
            end
            W_WDATA:
              if (r_beat == r_last_beat) r_work <= W_TWR;
              else r_beat <= r_beat + LEN_W'(1);
            W_TWR:
              if (r_cnt == CNT_W'(T_WR - 1)) begin
                r_cnt   <= '0;
                r_work  <= W_IDLE;
                r_grant <= '0;
              end else r_cnt <= r_cnt + CNT_W'(1);
            W_AR: begin
              r_cnt  <= '0;
              r_work <= (T_RFC > 1) ? W_TRFC : W_IDLE;
            end
            W_TRFC:
              if (r_cnt == CNT_W'(T_RFC - 2)) begin
                r_cnt  <= '0;
                r_work <= W_IDLE;
              end else r_cnt <= r_cnt + CNT_W'(1);
            default: r_work <= W_IDLE;
          endcase
        default: r_init <= I_WAIT;
      endcase
    end
  end

  // Refresh owed count: tick adds, AR entry consumes, both cancel out.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_rcnt <= '0;
      r_pend <= '0;
    end else begin
      if (r_init == I_DONE)
        r_rcnt <= w_tick ? '0 : r_rcnt + RC_W'(1);
      case ({w_tick, w_ar_go})
        2'b10:
          if (r_pend != PW'(REF_MAX)) r_pend <= r_pend + PW'(1);
        2'b01: r_pend <= r_pend - PW'(1);
        default: r_pend <= r_pend;
      endcase
    end
  end

  always_comb begin
    w_cmd = CMD_NOP;
    case (r_init)
      I_PRE:  w_cmd = CMD_PRE;
      I_REF1: w_cmd = CMD_REF;
      I_REF2: w_cmd = CMD_REF;
      I_MRS:  w_cmd = CMD_MRS;
      I_DONE:
        case (r_work)
          W_ACT:   w_cmd = CMD_ACT;
          W_RD:    w_cmd = CMD_RD;
          W_WR:    w_cmd = CMD_WR;
          W_AR:    w_cmd = CMD_REF;
          default: w_cmd = CMD_NOP;
        endcase
      default: w_cmd = CMD_NOP;
    endcase
  end

  assign sdram_cmd   = w_cmd;
  assign grant       = r_grant;
  assign sys_rw_n    = r_rw_n;
  assign init_done   = (r_init == I_DONE);
  assign busy        = !w_idle;
  assign ref_pending = r_pend;
  assign rd_ack      = (r_work == W_RDATA);
  assign wr_ack      = (r_work == W_WR) || (r_work == W_WDATA);
  assign xfer_done   =
    ((r_work == W_RDATA) && (r_beat == r_last_beat)) ||
    ((r_work == W_TWR) && (r_cnt == CNT_W'(T_WR - 1)));

endmodule

// File: tb/tb_sdram_ctrl_mc.sv
// Directed bench for sdram_ctrl_mc: init sequence, round-robin writes,
// read timing, refresh postponement, reset mid-burst, zero-length read.
module tb_sdram_ctrl_mc;

  localparam int NCH   = 2;
  localparam int LEN_W = 9;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NCH-1:0]         rd_req;
  logic [NCH-1:0]         wr_req;
  logic [NCH*LEN_W-1:0]   xfer_len;
  logic [NCH-1:0]         grant;
  logic [2:0]             cmd;
  logic                   rd_ack;
  logic                   wr_ack;
  logic                   xfer_done;
  logic                   sys_rw_n;
  logic                   init_done;
  logic                   busy;
  logic [1:0]             ref_pending;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdram_ctrl_mc #(
    .NCH(NCH), .LEN_W(LEN_W), .T_INIT(10),
    .T_REFI(20), .REF_MAX(2)
  ) dut (
    .clk_100m    (clk),
    .rst_n       (rst_n),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .xfer_len    (xfer_len),
    .grant       (grant),
    .sdram_cmd   (cmd),
    .rd_ack      (rd_ack),
    .wr_ack      (wr_ack),
    .xfer_done   (xfer_done),
    .sys_rw_n    (sys_rw_n),
    .init_done   (init_done),
    .busy        (busy),
    .ref_pending (ref_pending)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    int t;
    int acks;
    int mx;
    int forced;
    bit armed;
    logic [31:0] e;

    rst_n = 1'b0;
    rd_req = '0;
    wr_req = '0;
    xfer_len = '0;
    step(3);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_rd_ack", 32'(rd_ack), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_done", 32'(xfer_done), 0);
    chk("rst_rw", 32'(sys_rw_n), 0);
    chk("rst_init", 32'(init_done), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_pend", 32'(ref_pending), 0);

    // this negedge is cycle 0 of the init sequence
    rst_n = 1'b1;
    for (int c = 0; c <= 28; c++) begin
      e = 0;
      if (c == 10) e = 1;
      if (c == 12 || c == 19) e = 2;
      if (c == 26) e = 3;
      chk("init_cmd", 32'(cmd), e);
      if (c == 27) chk("init_done27", 32'(init_done), 0);
      if (c == 28) begin
        chk("init_done28", 32'(init_done), 1);
        chk("idle_busy", 32'(busy), 0);
      end
      if (c < 28) step(1);
    end

    // round-robin single-beat writes from both channels
    wr_req = 2'b11;
    xfer_len = {9'd1, 9'd1};
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (cmd != 3'd4 && t < 50) begin
        step(1);
        t++;
      end
      chk("rr_act_seen", 32'(cmd), 4);
      if (k == 0) chk("rr_req_to_act", 32'(t), 1);
      chk("rr_grant", 32'(grant), (k % 2 == 0) ? 1 : 2);
      chk("rr_rw_n", 32'(sys_rw_n), 1);
      t = 0;
      acks = 0;
      while (!xfer_done && t < 50) begin
        acks += int'(wr_ack);
        step(1);
        t++;
      end
      acks += int'(wr_ack);
      chk("rr_occupancy", 32'(t), 4);
      chk("rr_wr_beats", 32'(acks), 1);
      if (k == 2) wr_req[0] = 1'b0;
      if (k == 3) wr_req[1] = 1'b0;
    end

    // ch0 read, 4 beats, cycle-exact relative to ACT
    t = 0;
    while (!(busy == 1'b0 && ref_pending == 2'd0) && t < 50) begin
      step(1);
      t++;
    end
    chk("rd_idle_wait", 32'(busy), 0);
    rd_req[0] = 1'b1;
    xfer_len[0 +: LEN_W] = 9'd4;
    for (int o = 0; o <= 9; o++) begin
      step(1);
      e = 0;
      if (o == 0) e = 4;
      if (o == 2) e = 5;
      chk("rd_cmd", 32'(cmd), e);
      chk("rd_ack", 32'(rd_ack), (o >= 5 && o <= 8) ? 1 : 0);
      chk("rd_done", 32'(xfer_done), (o == 8) ? 1 : 0);
      chk("rd_grant", 32'(grant), (o <= 8) ? 1 : 0);
      if (o == 0) chk("rd_rw_n", 32'(sys_rw_n), 0);
      if (o == 8) rd_req[0] = 1'b0;
    end

    // continuous long reads: refresh backlog must saturate and force REF
    t = 0;
    while (!(busy == 1'b0 && ref_pending == 2'd0) && t < 50) begin
      step(1);
      t++;
    end
    chk("ref_idle_wait", 32'(busy), 0);
    rd_req[0] = 1'b1;
    xfer_len[0 +: LEN_W] = 9'd20;
    mx = 0;
    forced = 0;
    armed = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step(1);
      if (armed) begin
        chk("ref_before_grant", 32'(cmd), 2);
        forced++;
      end
      armed = (busy == 1'b0 && ref_pending == 2'd2);
      if (int'(ref_pending) > mx) mx = int'(ref_pending);
    end
    chk("ref_pend_max", 32'(mx), 2);
    chk("ref_forced_seen", 32'(forced > 0), 1);
    rd_req[0] = 1'b0;
    t = 0;
    while (!(busy == 1'b0 && ref_pending == 2'd0) && t < 100) begin
      step(1);
      t++;
    end
    chk("ref_drain", 32'(ref_pending), 0);

    // reset asserted during the second read beat
    rd_req[0] = 1'b1;
    xfer_len[0 +: LEN_W] = 9'd4;
    t = 0;
    while (!rd_ack && t < 50) begin
      step(1);
      t++;
    end
    chk("mid_beat1", 32'(rd_ack), 1);
    step(1);
    chk("mid_beat2", 32'(rd_ack), 1);
    rst_n = 1'b0;
    rd_req = '0;
    step(1);
    chk("mid_rd_ack", 32'(rd_ack), 0);
    chk("mid_grant", 32'(grant), 0);
    chk("mid_cmd", 32'(cmd), 0);
    chk("mid_init", 32'(init_done), 0);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_pend", 32'(ref_pending), 0);
    chk("mid_done", 32'(xfer_done), 0);
    rst_n = 1'b1;
    step(10);
    chk("reinit_pre", 32'(cmd), 1);
    step(18);
    chk("reinit_done", 32'(init_done), 1);

    // zero-length read on ch1 is a single beat
    rd_req[1] = 1'b1;
    xfer_len[LEN_W +: LEN_W] = 9'd0;
    t = 0;
    acks = 0;
    while (!xfer_done && t < 30) begin
      acks += int'(rd_ack);
      step(1);
      t++;
    end
    acks += int'(rd_ack);
    chk("len0_occ", 32'(t), 6);
    chk("len0_ack_at_done", 32'(rd_ack), 1);
    chk("len0_beats", 32'(acks), 1);
    chk("len0_grant", 32'(grant), 2);
    chk("len0_rw_n", 32'(sys_rw_n), 0);
    rd_req[1] = 1'b0;
    step(1);
    chk("len0_after_ack", 32'(rd_ack), 0);
    chk("len0_after_grant", 32'(grant), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
